// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared Aardvark definitions: widths, opcode field bounds,
//               fetch FSM encoding and the branch-offset sign extension.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

   localparam int c_pc_w_def    = 8;
   localparam int c_instr_w_def = 8;

   // opcode occupies the top nibble of the instruction word, offset the bottom
   localparam int c_opc_w = 4;
   localparam int c_off_w = 4;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } fetch_state_e;

   function automatic logic [c_pc_w_def-1:0] sext_off(input logic [c_off_w-1:0] off);
      return {{(c_pc_w_def-c_off_w){off[c_off_w-1]}}, off};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Priority selection of the next program counter (jr > j/jal >
//               taken beq > sequential), all arithmetic modulo 2^PC_W.
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
   import fetch_unit_pkg::*;
#(
   parameter int PC_W = c_pc_w_def
) (
   input  logic [PC_W-1:0]    pc_plus1,
   input  logic [c_off_w-1:0] ir_off,
   input  logic               jrctrl,
   input  logic               jctrl,
   input  logic               jalctrl,
   input  logic               beqctrl,
   input  logic               zero,
   input  logic [PC_W-1:0]    ra_val,
   input  logic [PC_W-1:0]    jump_target,
   output logic [PC_W-1:0]    next_pc
);

   logic [PC_W-1:0] w_off_sext;
   logic [PC_W-1:0] w_branch_pc;

   assign w_off_sext  = {{(PC_W-c_off_w){ir_off[c_off_w-1]}}, ir_off};
   assign w_branch_pc = pc_plus1 + w_off_sext;

   always_comb begin
      next_pc = pc_plus1;
      if (jrctrl) begin
         next_pc = ra_val;
      end else if (jctrl || jalctrl) begin
         next_pc = jump_target;
      end else if (beqctrl && zero) begin
         next_pc = w_branch_pc;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Aardvark instruction fetch: PC, imem req/ack handshake,
//               instruction register and next-PC update on retirement.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              PC_W     = c_pc_w_def,
   parameter int              INSTR_W  = c_instr_w_def,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] ir,
   output logic [c_opc_w-1:0] opcode,
   output logic               ir_valid,
   output logic [PC_W-1:0]    pc,
   output logic [PC_W-1:0]    pc_plus1,
   input  logic               exec_done,
   input  logic               stall,
   input  logic               jctrl,
   input  logic               jalctrl,
   input  logic               jrctrl,
   input  logic               beqctrl,
   input  logic               zero,
   input  logic [PC_W-1:0]    ra_val,
   input  logic [PC_W-1:0]    jump_target
);

   fetch_state_e       r_state;
   logic               r_req;
   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ir;
   logic               r_ir_valid;
   logic [PC_W-1:0]    w_pc_plus1;
   logic [PC_W-1:0]    w_next_pc;
   logic               w_retire;

   assign w_pc_plus1 = r_pc + PC_W'(1);
   assign w_retire   = exec_done && !stall;

   next_pc_sel #(
      .PC_W (PC_W)
   ) u_next_pc_sel (
      .pc_plus1    (w_pc_plus1),
      .ir_off      (r_ir[c_off_w-1:0]),
      .jrctrl      (jrctrl),
      .jctrl       (jctrl),
      .jalctrl     (jalctrl),
      .beqctrl     (beqctrl),
      .zero        (zero),
      .ra_val      (ra_val),
      .jump_target (jump_target),
      .next_pc     (w_next_pc)
   );

   // r_req mirrors (r_state == ST_FETCH) so the request never depends on ack
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_BOOT;
         r_req      <= 1'b0;
         r_pc       <= RESET_PC;
         r_ir       <= '0;
         r_ir_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state <= ST_FETCH;
               r_req   <= 1'b1;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  r_ir       <= imem_rdata;
                  r_ir_valid <= 1'b1;
                  r_state    <= ST_EXEC;
                  r_req      <= 1'b0;
               end
            end
            ST_EXEC: begin
               if (w_retire) begin
                  r_pc       <= w_next_pc;
                  r_ir_valid <= 1'b0;
                  r_state    <= ST_FETCH;
                  r_req      <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_BOOT;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req  = r_req;
   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign pc_plus1  = w_pc_plus1;
   assign ir        = r_ir;
   assign ir_valid  = r_ir_valid;
   assign opcode    = r_ir[INSTR_W-1 -: c_opc_w];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed, table-driven self-checking bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       imem_req;
   logic [7:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_rdata = 8'h00;
   logic [7:0] ir;
   logic [3:0] opcode;
   logic       ir_valid;
   logic [7:0] pc;
   logic [7:0] pc_plus1;
   logic       exec_done = 1'b0;
   logic       stall = 1'b0;
   logic       jctrl = 1'b0;
   logic       jalctrl = 1'b0;
   logic       jrctrl = 1'b0;
   logic       beqctrl = 1'b0;
   logic       zero = 1'b0;
   logic [7:0] ra_val = 8'h00;
   logic [7:0] jump_target = 8'h00;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .ir          (ir),
      .opcode      (opcode),
      .ir_valid    (ir_valid),
      .pc          (pc),
      .pc_plus1    (pc_plus1),
      .exec_done   (exec_done),
      .stall       (stall),
      .jctrl       (jctrl),
      .jalctrl     (jalctrl),
      .jrctrl      (jrctrl),
      .beqctrl     (beqctrl),
      .zero        (zero),
      .ra_val      (ra_val),
      .jump_target (jump_target)
   );

   typedef struct {
      logic [7:0] rdata;
      logic       jr;
      logic       j;
      logic       jal;
      logic       beq;
      logic       z;
      logic [7:0] ra;
      logic [7:0] jt;
      logic [7:0] exp_pc;
   } vec_t;

   vec_t       tbl[17];
   int         n_cmp = 0;
   int         n_err = 0;
   logic [7:0] cur_pc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // waits (bounded) for a request, then acks after lat idle request cycles
   task automatic fetch(input logic [7:0] d, input int lat);
      int k;
      k = 0;
      while (imem_req !== 1'b1 && k < 16) begin
         tick();
         k++;
      end
      chk("req_wait", {31'd0, imem_req}, 32'd1);
      for (int i = 0; i < lat; i++) begin
         chk("req_held", {31'd0, imem_req}, 32'd1);
         chk("addr_steady", {24'd0, imem_addr}, {24'd0, cur_pc});
         tick();
      end
      chk("fetch_addr", {24'd0, imem_addr}, {24'd0, cur_pc});
      imem_ack   = 1'b1;
      imem_rdata = d;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      chk("ir", {24'd0, ir}, {24'd0, d});
      chk("opcode", {28'd0, opcode}, {28'd0, d[7:4]});
      chk("ir_valid_set", {31'd0, ir_valid}, 32'd1);
      chk("req_drop", {31'd0, imem_req}, 32'd0);
   endtask

   task automatic retire(input vec_t v);
      logic [7:0] exp_p1;
      exp_p1    = cur_pc + 8'd1;
      jrctrl    = v.jr;
      jctrl     = v.j;
      jalctrl   = v.jal;
      beqctrl   = v.beq;
      zero      = v.z;
      ra_val    = v.ra;
      jump_target = v.jt;
      exec_done = 1'b1;
      chk("pc_hold", {24'd0, pc}, {24'd0, cur_pc});
      chk("pc_plus1", {24'd0, pc_plus1}, {24'd0, exp_p1});
      tick();
      {jrctrl, jctrl, jalctrl, beqctrl, zero, exec_done} = 6'd0;
      ra_val      = 8'h00;
      jump_target = 8'h00;
      chk("next_pc", {24'd0, pc}, {24'd0, v.exp_pc});
      chk("ir_valid_clr", {31'd0, ir_valid}, 32'd0);
      chk("refetch_req", {31'd0, imem_req}, 32'd1);
      chk("refetch_addr", {24'd0, imem_addr}, {24'd0, v.exp_pc});
      cur_pc = v.exp_pc;
   endtask

   initial begin
      vec_t vs;
      tbl[0]  = '{8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03};
      tbl[1]  = '{8'h61, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h80, 8'h40};
      tbl[2]  = '{8'h72, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h80, 8'h80};
      tbl[3]  = '{8'h83, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h10};
      tbl[4]  = '{8'hAE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h11};
      tbl[5]  = '{8'h84, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 8'h10};
      tbl[6]  = '{8'hAE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h0F};
      tbl[7]  = '{8'h95, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 8'hFF};
      tbl[8]  = '{8'h16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[9]  = '{8'hA7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h08};
      tbl[10] = '{8'hA8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h01};
      tbl[11] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'h02};
      tbl[12] = '{8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h30, 8'h30};
      tbl[13] = '{8'h7B, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h90, 8'h05};
      tbl[14] = '{8'hA8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFE};
      tbl[15] = '{8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF};
      tbl[16] = '{8'hAF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 8'h00};

      // reset then immediate-ack fetch
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_ir", {24'd0, ir}, 32'd0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_pc", {24'd0, pc}, 32'd0);
      rst_n = 1'b1;
      chk("boot_req", {31'd0, imem_req}, 32'd0);
      chk("boot_addr", {24'd0, imem_addr}, 32'd0);
      tick();
      chk("first_req", {31'd0, imem_req}, 32'd1);
      cur_pc = 8'h00;
      fetch(8'h35, 0);
      vs = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h01};
      retire(vs);

      // ack three cycles after the request
      fetch(8'h12, 3);
      vs.exp_pc = 8'h02;
      retire(vs);

      for (int i = 0; i < 17; i++) begin
         fetch(tbl[i].rdata, i % 3);
         retire(tbl[i]);
      end

      // stall blocks retirement; stray ack in EXEC is ignored
      fetch(8'h5C, 0);
      exec_done = 1'b1;
      stall     = 1'b1;
      jump_target = 8'h55;
      for (int i = 0; i < 4; i++) begin
         imem_ack   = (i == 1);
         imem_rdata = 8'hC3;
         tick();
         chk("stall_pc", {24'd0, pc}, {24'd0, cur_pc});
         chk("stall_ir", {24'd0, ir}, 32'h5C);
         chk("stall_valid", {31'd0, ir_valid}, 32'd1);
      end
      imem_ack    = 1'b0;
      imem_rdata  = 8'h00;
      jump_target = 8'h00;
      stall       = 1'b0;
      vs.exp_pc   = 8'h01;
      retire(vs);

      // asynchronous reset in the middle of a pending fetch
      fetch(8'h9A, 0);
      vs = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h20, 8'h20};
      retire(vs);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_req", {31'd0, imem_req}, 32'd0);
      chk("async_addr", {24'd0, imem_addr}, 32'd0);
      chk("async_ir", {24'd0, ir}, 32'd0);
      chk("async_valid", {31'd0, ir_valid}, 32'd0);
      imem_ack   = 1'b1;
      imem_rdata = 8'hEE;
      tick();
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 8'h00;
      rst_n = 1'b1;
      chk("late_ack_ir", {24'd0, ir}, 32'd0);
      chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
      chk("reboot_req", {31'd0, imem_req}, 32'd0);
      cur_pc = 8'h00;
      fetch(8'h77, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
